// File: rtl/dcache_pkg.sv
// Shared data-cache definitions.
// Holds the default address/index geometry, the memory command encodings
// carried on request buses and the requester identifiers used by the
// array-port scheduler. It has no ports.
package dcache_pkg;

    localparam int DC_ADDR_BITS = 40;
    localparam int DC_IDX_BITS  = 6;
    localparam int DC_IDX_LSB   = 6;

    // Memory command encodings.
    localparam logic [4:0] M_XRD       = 5'b00000;
    localparam logic [4:0] M_XWR       = 5'b00001;
    localparam logic [4:0] M_PFR       = 5'b00010;
    localparam logic [4:0] M_PFW       = 5'b00011;
    localparam logic [4:0] M_XA_SWAP   = 5'b00100;
    localparam logic [4:0] M_FLUSH_ALL = 5'b00101;
    localparam logic [4:0] M_XLR       = 5'b00110;
    localparam logic [4:0] M_XSC       = 5'b00111;
    localparam logic [4:0] M_XA_ADD    = 5'b01000;

    // Requesters of the shared meta/data array read port.
    typedef enum logic [2:0] {
        SRC_WB      = 3'd0,
        SRC_PROBE   = 3'd1,
        SRC_REPLAY  = 3'd2,
        SRC_RECYCLE = 3'd3,
        SRC_CPU     = 3'd4
    } dc_src_e;

endpackage

// File: rtl/dcache_recycle_buf.sv
// Single-entry recycle buffer.
// Captures the stage-2 request when stage 2 asks for re-execution and holds
// it until the scheduler grants it the array port.
// Ports:
//   clk, reset           clock and synchronous active-low reset
//   cap_req              stage 2 demands a recycle of its request
//   drain                buffered entry is granted this cycle
//   in_*                 stage-2 request fields
//   rec_valid, rec_*     buffered entry and its valid flag
module dcache_recycle_buf
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS = DC_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cap_req,
    input  logic                 drain,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [8:0]           in_tag,
    input  logic [4:0]           in_cmd,
    input  logic [2:0]           in_typ,
    input  logic                 in_phys,
    input  logic [63:0]          in_data,
    output logic                 rec_valid,
    output logic [ADDR_BITS-1:0] rec_addr,
    output logic [8:0]           rec_tag,
    output logic [4:0]           rec_cmd,
    output logic [2:0]           rec_typ,
    output logic                 rec_phys,
    output logic [63:0]          rec_data
);

    logic                 valid_q, valid_d;
    logic [ADDR_BITS-1:0] addr_q,  addr_d;
    logic [8:0]           tag_q,   tag_d;
    logic [4:0]           cmd_q,   cmd_d;
    logic [2:0]           typ_q,   typ_d;
    logic                 phys_q,  phys_d;
    logic [63:0]          data_q,  data_d;
    logic                 capture_s;

    // Next-state: a free slot, or one draining this very cycle, may take a new entry.
    always_comb begin
        capture_s = cap_req && (!valid_q || drain);
        valid_d   = valid_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        cmd_d     = cmd_q;
        typ_d     = typ_q;
        phys_d    = phys_q;
        data_d    = data_q;
        if (capture_s) begin
            valid_d = 1'b1;
            addr_d  = in_addr;
            tag_d   = in_tag;
            cmd_d   = in_cmd;
            typ_d   = in_typ;
            phys_d  = in_phys;
            data_d  = in_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage; reset discards any buffered request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            tag_q   <= 9'd0;
            cmd_q   <= 5'd0;
            typ_q   <= 3'd0;
            phys_q  <= 1'b0;
            data_q  <= 64'd0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            cmd_q   <= cmd_d;
            typ_q   <= typ_d;
            phys_q  <= phys_d;
            data_q  <= data_d;
        end
    end

    assign rec_valid = valid_q;
    assign rec_addr  = addr_q;
    assign rec_tag   = tag_q;
    assign rec_cmd   = cmd_q;
    assign rec_typ   = typ_q;
    assign rec_phys  = phys_q;
    assign rec_data  = data_q;

endmodule

// File: rtl/dcache_s1_sched_chk.sv
// Property checker for the s1 scheduler.
// Stage 2 must never ask for a recycle while the buffer is occupied and not
// draining, since that request would be silently dropped.
// Ports: clk, reset, s2_recycle, rec_valid, rec_gnt (all inputs).
module dcache_s1_sched_chk (
    input logic clk,
    input logic reset,
    input logic s2_recycle,
    input logic rec_valid,
    input logic rec_gnt
);

    // A recycle request must find the buffer free or draining.
    a_no_lost_recycle : assert property (@(posedge clk) disable iff (!reset)
        !(s2_recycle && rec_valid && !rec_gnt));

endmodule

// File: rtl/dcache_s1_sched.sv
// Data-cache s1 front-end scheduler.
// Arbitrates the shared meta/data array read port between writeback, probe,
// MSHR replay, the internal recycle buffer and the CPU (fixed priority in
// that order, except that a CPU starved for STARVE_LIMIT cycles outranks
// replay when nothing is waiting in the recycle buffer), and loads the s1
// pipeline registers from the granted request.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   array_busy                  array port taken by refill/write; no grants
//   wb_*, probe_*               index-only read requesters
//   replay_*, cpu_req_*         full request requesters
//   s2_recycle, s2_req_*        stage-2 recycle request and its fields
//   array_read_valid/idx        array read strobe and set index
//   s1_*                        registered s1 qualifiers and request fields
module dcache_s1_sched
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS    = DC_ADDR_BITS,
    parameter int IDX_BITS     = DC_IDX_BITS,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_BITS     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 array_busy,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [IDX_BITS-1:0]  wb_idx,
    input  logic                 probe_valid,
    output logic                 probe_ready,
    input  logic [IDX_BITS-1:0]  probe_idx,
    input  logic                 replay_valid,
    output logic                 replay_ready,
    input  logic [ADDR_BITS-1:0] replay_addr,
    input  logic [8:0]           replay_tag,
    input  logic [4:0]           replay_cmd,
    input  logic [2:0]           replay_typ,
    input  logic                 replay_phys,
    input  logic                 cpu_req_valid,
    output logic                 cpu_req_ready,
    input  logic [ADDR_BITS-1:0] cpu_req_addr,
    input  logic [8:0]           cpu_req_tag,
    input  logic [4:0]           cpu_req_cmd,
    input  logic [2:0]           cpu_req_typ,
    input  logic                 cpu_req_phys,
    input  logic                 s2_recycle,
    input  logic [ADDR_BITS-1:0] s2_req_addr,
    input  logic [8:0]           s2_req_tag,
    input  logic [4:0]           s2_req_cmd,
    input  logic [2:0]           s2_req_typ,
    input  logic                 s2_req_phys,
    input  logic [63:0]          s2_req_data,
    output logic                 array_read_valid,
    output logic [IDX_BITS-1:0]  array_read_idx,
    output logic                 s1_valid,
    output logic                 s1_replay,
    output logic                 s1_recycled,
    output logic                 s1_clk_en,
    output logic [ADDR_BITS-1:0] s1_req_addr,
    output logic [8:0]           s1_req_tag,
    output logic [4:0]           s1_req_cmd,
    output logic [2:0]           s1_req_typ,
    output logic                 s1_req_phys,
    output logic [63:0]          s1_req_data
);

    localparam int IDX_LSB = DC_IDX_LSB;

    logic                 rec_valid_s;
    logic [ADDR_BITS-1:0] rec_addr_s;
    logic [8:0]           rec_tag_s;
    logic [4:0]           rec_cmd_s;
    logic [2:0]           rec_typ_s;
    logic                 rec_phys_s;
    logic [63:0]          rec_data_s;

    logic    starve_pri_s, rec_ready_s;
    logic    wb_gnt_s, probe_gnt_s, replay_gnt_s, rec_gnt_s, cpu_gnt_s;
    dc_src_e src_s;

    logic [CNT_BITS-1:0]  starve_q, starve_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_replay_q, s1_replay_d;
    logic                 s1_recycled_q, s1_recycled_d;
    logic                 s1_clk_en_q, s1_clk_en_d;
    logic [ADDR_BITS-1:0] s1_addr_q, s1_addr_d;
    logic [8:0]           s1_tag_q, s1_tag_d;
    logic [4:0]           s1_cmd_q, s1_cmd_d;
    logic [2:0]           s1_typ_q, s1_typ_d;
    logic                 s1_phys_q, s1_phys_d;
    logic [63:0]          s1_data_q, s1_data_d;

    dcache_recycle_buf #(
        .ADDR_BITS (ADDR_BITS)
    ) u_recycle_buf (
        .clk       (clk),
        .reset     (reset),
        .cap_req   (s2_recycle),
        .drain     (rec_gnt_s),
        .in_addr   (s2_req_addr),
        .in_tag    (s2_req_tag),
        .in_cmd    (s2_req_cmd),
        .in_typ    (s2_req_typ),
        .in_phys   (s2_req_phys),
        .in_data   (s2_req_data),
        .rec_valid (rec_valid_s),
        .rec_addr  (rec_addr_s),
        .rec_tag   (rec_tag_s),
        .rec_cmd   (rec_cmd_s),
        .rec_typ   (rec_typ_s),
        .rec_phys  (rec_phys_s),
        .rec_data  (rec_data_s)
    );

    dcache_s1_sched_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .s2_recycle (s2_recycle),
        .rec_valid  (rec_valid_s),
        .rec_gnt    (rec_gnt_s)
    );

    // Fixed-priority readies and grants. The CPU is held off while a recycled
    // request waits so that the older request re-executes first.
    always_comb begin
        starve_pri_s  = (starve_q == CNT_BITS'(STARVE_LIMIT)) && !rec_valid_s;
        wb_ready      = 1'b0;
        probe_ready   = 1'b0;
        replay_ready  = 1'b0;
        rec_ready_s   = 1'b0;
        cpu_req_ready = 1'b0;
        if (array_busy) begin
            wb_ready      = 1'b0;
            probe_ready   = 1'b0;
            replay_ready  = 1'b0;
            rec_ready_s   = 1'b0;
            cpu_req_ready = 1'b0;
        end else begin
            wb_ready      = 1'b1;
            probe_ready   = !wb_valid;
            // A starved CPU pushes replay down one rank.
            replay_ready  = !wb_valid && !probe_valid && !(starve_pri_s && cpu_req_valid);
            rec_ready_s   = !wb_valid && !probe_valid && !replay_valid;
            cpu_req_ready = !rec_valid_s && !wb_valid && !probe_valid
                            && (!replay_valid || starve_pri_s);
        end
        wb_gnt_s     = wb_valid && wb_ready;
        probe_gnt_s  = probe_valid && probe_ready;
        replay_gnt_s = replay_valid && replay_ready;
        rec_gnt_s    = rec_valid_s && rec_ready_s;
        cpu_gnt_s    = cpu_req_valid && cpu_req_ready;
    end

    // Granted source and the set index it reads.
    always_comb begin
        if (wb_gnt_s) begin
            src_s = SRC_WB;
        end else if (probe_gnt_s) begin
            src_s = SRC_PROBE;
        end else if (replay_gnt_s) begin
            src_s = SRC_REPLAY;
        end else if (rec_gnt_s) begin
            src_s = SRC_RECYCLE;
        end else begin
            src_s = SRC_CPU;
        end
        array_read_valid = wb_gnt_s || probe_gnt_s || replay_gnt_s || rec_gnt_s || cpu_gnt_s;
        case (src_s)
            SRC_WB:      array_read_idx = wb_idx;
            SRC_PROBE:   array_read_idx = probe_idx;
            SRC_REPLAY:  array_read_idx = replay_addr[IDX_LSB +: IDX_BITS];
            SRC_RECYCLE: array_read_idx = rec_addr_s[IDX_LSB +: IDX_BITS];
            SRC_CPU:     array_read_idx = cpu_req_addr[IDX_LSB +: IDX_BITS];
            default:     array_read_idx = '0;
        endcase
    end

    // s1 next state and CPU starvation counter.
    always_comb begin
        s1_clk_en_d   = replay_gnt_s || rec_gnt_s || cpu_gnt_s;
        s1_valid_d    = rec_gnt_s || cpu_gnt_s;
        s1_replay_d   = replay_gnt_s;
        s1_recycled_d = rec_gnt_s;
        s1_addr_d     = s1_addr_q;
        s1_tag_d      = s1_tag_q;
        s1_cmd_d      = s1_cmd_q;
        s1_typ_d      = s1_typ_q;
        s1_phys_d     = s1_phys_q;
        case (src_s)
            SRC_REPLAY: begin
                s1_addr_d = replay_addr;
                s1_tag_d  = replay_tag;
                s1_cmd_d  = replay_cmd;
                s1_typ_d  = replay_typ;
                s1_phys_d = replay_phys;
            end
            SRC_RECYCLE: begin
                s1_addr_d = rec_addr_s;
                s1_tag_d  = rec_tag_s;
                s1_cmd_d  = rec_cmd_s;
                s1_typ_d  = rec_typ_s;
                s1_phys_d = rec_phys_s;
            end
            SRC_CPU: begin
                // SRC_CPU is also the idle selection, so qualify with the grant.
                if (cpu_gnt_s) begin
                    s1_addr_d = cpu_req_addr;
                    s1_tag_d  = cpu_req_tag;
                    s1_cmd_d  = cpu_req_cmd;
                    s1_typ_d  = cpu_req_typ;
                    s1_phys_d = cpu_req_phys;
                end else begin
                    s1_addr_d = s1_addr_q;
                end
            end
            default: begin
                s1_addr_d = s1_addr_q;
            end
        endcase
        // Only recycled requests carry store data into s1.
        if (rec_gnt_s) begin
            s1_data_d = rec_data_s;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (cpu_req_valid && !cpu_gnt_s) begin
            if (starve_q == CNT_BITS'(STARVE_LIMIT)) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + CNT_BITS'(1);
            end
        end else begin
            starve_d = '0;
        end
    end

    // s1 pipeline registers and starvation counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_replay_q   <= 1'b0;
            s1_recycled_q <= 1'b0;
            s1_clk_en_q   <= 1'b0;
            s1_addr_q     <= '0;
            s1_tag_q      <= 9'd0;
            s1_cmd_q      <= 5'd0;
            s1_typ_q      <= 3'd0;
            s1_phys_q     <= 1'b1;
            s1_data_q     <= 64'd0;
        end else begin
            starve_q      <= starve_d;
            s1_valid_q    <= s1_valid_d;
            s1_replay_q   <= s1_replay_d;
            s1_recycled_q <= s1_recycled_d;
            s1_clk_en_q   <= s1_clk_en_d;
            s1_addr_q     <= s1_addr_d;
            s1_tag_q      <= s1_tag_d;
            s1_cmd_q      <= s1_cmd_d;
            s1_typ_q      <= s1_typ_d;
            s1_phys_q     <= s1_phys_d;
            s1_data_q     <= s1_data_d;
        end
    end

    assign s1_valid    = s1_valid_q;
    assign s1_replay   = s1_replay_q;
    assign s1_recycled = s1_recycled_q;
    assign s1_clk_en   = s1_clk_en_q;
    assign s1_req_addr = s1_addr_q;
    assign s1_req_tag  = s1_tag_q;
    assign s1_req_cmd  = s1_cmd_q;
    assign s1_req_typ  = s1_typ_q;
    assign s1_req_phys = s1_phys_q;
    assign s1_req_data = s1_data_q;

endmodule

// File: doc/dcache_s1_sched.md
Name: dcache_s1_sched

Overview:
Front-end scheduler for the non-blocking data cache's shared meta/data array read port and the s1 pipeline register set.
- Requesters, one grant per cycle by fixed priority with a starvation guard:
  - writeback reader (wb)
  - prober (probe)
  - MSHR replay
  - internal recycle buffer (s2 nack/ECC recycle)
  - CPU
- Produces the array read strobe/index plus s1_valid, s1_replay, s1_recycled, s1_clk_en and the s1_req_* fields consumed by stage 2.

Parameters:
- ADDR_BITS, 40, request address width
- IDX_BITS, 6, set index width (addr[11:6])
- STARVE_LIMIT, 8, consecutive blocked CPU cycles before CPU outranks replay
- CNT_BITS, 4, starvation counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- array_busy  in  1  array port held by refill/write this cycle; no grants
- wb_valid / wb_ready  in/out  1/1  writeback meta+data read request
- wb_idx  in  IDX_BITS  set for writeback read
- probe_valid / probe_ready  in/out  1/1  prober meta read request
- probe_idx  in  IDX_BITS  set for probe read
- replay_valid / replay_ready  in/out  1/1  MSHR replay request
- replay_addr  in  ADDR_BITS  replay address
- replay_tag  in  9  replay tag
- replay_cmd  in  5  replay command
- replay_typ  in  3  replay type
- replay_phys  in  1  replay physical-address flag
- cpu_req_valid / cpu_req_ready  in/out  1/1  CPU request
- cpu_req_addr, cpu_req_tag, cpu_req_cmd, cpu_req_typ, cpu_req_phys  in  ADDR_BITS/9/5/3/1  CPU request fields
- s2_recycle  in  1  stage 2 demands re-execution of its request
- s2_req_addr, s2_req_tag, s2_req_cmd, s2_req_typ, s2_req_phys, s2_req_data  in  ADDR_BITS/9/5/3/1/64  stage-2 request to capture
- array_read_valid  out  1  read strobe to meta and data arrays
- array_read_idx  out  IDX_BITS  set index for the read
- s1_valid, s1_replay, s1_recycled, s1_clk_en  out  1 each  s1 pipeline qualifiers (registered)
- s1_req_addr, s1_req_tag, s1_req_cmd, s1_req_typ, s1_req_phys, s1_req_data  out  ADDR_BITS/9/5/3/1/64  s1 request fields (registered)

Behaviour:
- Priority: wb > probe > replay > recycle > cpu.
  - Exception: starve_cnt == STARVE_LIMIT and rec_valid == 0 → cpu ranks above replay.
  - Recycle always precedes cpu, so ordering is preserved.
- array_busy = 1 → all readies 0, array_read_valid 0, no s1 load.
- Readies are combinational from the valids, rec_valid, starve_cnt and array_busy. A grant is valid & ready.
  - cpu_req_ready = 0 whenever rec_valid = 1.
- array_read_valid = any grant. array_read_idx = idx or addr[11:6] of the granted source (recycle uses the buffered addr).
- s1 registers update the cycle after a grant (latency 1):
  - s1_clk_en <= replay | recycle | cpu grant.
  - s1_valid <= cpu | recycle grant.
  - s1_replay <= replay grant.
  - s1_recycled <= recycle grant.
  - wb/probe grants leave s1_* fields unchanged and drive all four qualifiers to 0.
- s1_req_* fields load from the granted source only when s1_clk_en is being set.
  - s1_req_data loads only on recycle grant (buffered data); otherwise it holds.
- Recycle buffer, single entry:
  - s2_recycle & ~rec_valid → capture s2 fields, rec_valid <= 1.
  - Recycle grant → rec_valid <= 0.
  - Same-cycle grant + s2_recycle → recapture, rec_valid stays 1.
  - s2_recycle while rec_valid and not granted → ignored. Stage 2 guarantees this cannot occur; assertion flags it.
- Starvation counter (starve_cnt):
  - cpu_req_valid & ~cpu grant → increment, saturating at STARVE_LIMIT.
  - cpu grant or ~cpu_req_valid → 0.
- Reset values (reset == 0 at clk edge):
  - s1_valid, s1_replay, s1_recycled, s1_clk_en = 0.
  - s1_req_addr, tag, cmd, typ, data = 0; s1_req_phys = 1.
  - rec_valid = 0; starve_cnt = 0.
  - Reset mid-operation discards the recycle buffer content.
- Combinational outputs while reset is asserted are don't-care.

Decomposition:
- Shared package dcache_pkg: command encodings (M_XRD=0, M_XWR=1, …), IDX_BITS/ADDR_BITS constants, a source enum (SRC_WB, SRC_PROBE, SRC_REPLAY, SRC_RECYCLE, SRC_CPU).
- One sub-module: dcache_recycle_buf (single-entry capture/hold with valid).
- Priority select and starvation logic stay inline.

Test Plan:
- All five requesters valid the same cycle, starve_cnt = 0 → wb granted, array_read_idx = wb_idx; next cycle s1_clk_en = 0.
- Replay valid continuously with cpu valid; after 8 blocked cycles → cycle 9 grants cpu; s1_valid = 1, s1_replay = 0; starve_cnt returns to 0.
- s2_recycle with s2_req_addr = 0x80001040, s2_req_data = 0xDEAD → cpu_req_ready = 0; next idle cycle recycle granted, array_read_idx = 0x01; next cycle s1_recycled = 1, s1_req_data = 0xDEAD.
- array_busy = 1 for 3 cycles with cpu valid → no grants, starve_cnt = 3; busy drops → cpu granted.
- Recycle grant coincides with a new s2_recycle → rec_valid stays 1 holding the new fields.
- reset = 0 mid-stream with rec_valid = 1 → after edge all s1 qualifiers 0, s1_req_phys = 1, rec_valid = 0.
